// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder sequencer.
// Optional subtract support is enabled with the SERIAL_ADD_SUB_EN macro.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam state_t STATE_RST = IDLE;
    localparam logic   CARRY_RST = 1'b0;
    localparam logic   COUT_RST  = 1'b0;

    // Counter must be able to hold WIDTH itself, not just WIDTH-1.
    function automatic int cnt_w(input int width);
        return (width < 1) ? 1 : $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle between a controller and the serial adder sequencer.
// The sub select only exists when SERIAL_ADD_SUB_EN is defined.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

`ifdef SERIAL_ADD_SUB_EN
    modport master (output start, a, b, sub, input busy, done, sum, cout);
    modport slave  (input start, a, b, sub, output busy, done, sum, cout);
`else
    modport master (output start, a, b, input busy, done, sum, cout);
    modport slave  (input start, a, b, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/fa_cell.sv
// Full-adder cell made of two half adders and an OR; the only combinational
// arithmetic in the serial adder.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic s1;
    logic c1;
    logic c2;

    half_adder u_ha0 (.a(a),  .b(b),   .s(s1), .c(c1));
    half_adder u_ha1 (.a(s1), .b(cin), .s(s),  .c(c2));

    assign cout = c1 | c2;
endmodule

// File: rtl/half_adder.sv
// One-bit half adder, the building block of the shared full-adder cell.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add sequencer: latches operands, steps one bit pair per clock
// LSB-first through fa_cell, publishes sum/cout with a done pulse.
// Define SERIAL_ADD_SUB_EN to add the two's-complement subtract mode.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_add_ctrl_if.slave  bus
);
    import serial_add_pkg::*;

    localparam int             CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nx;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_nx;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             accept;
    logic             step;
    logic             last;
    logic             busy_c;
    logic             done_c;
    logic             b_bit;
    logic             fa_s;
    logic             fa_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= STATE_RST;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        step     = 1'b0;
        busy_c   = 1'b0;
        done_c   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                step   = 1'b1;
                busy_c = 1'b1;
                if (cnt == LAST) state_nx = DONE;
            end
            DONE: begin
                done_c   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign last = step && (cnt == LAST);

`ifdef SERIAL_ADD_SUB_EN
    logic sub_q;
    assign b_bit = b_sh[0] ^ sub_q;
`else
    assign b_bit = b_sh[0];
`endif

    fa_cell u_fa (
        .a    (a_sh[0]),
        .b    (b_bit),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_c)
    );

    // New bit enters at the MSB so after WIDTH steps bit 0 sits at the LSB.
    always_comb begin
        sum_nx            = sum_sh >> 1;
        sum_nx[WIDTH-1]   = fa_s;
    end

    // The result registers load on the final step so they are already valid
    // throughout the done cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            carry  <= CARRY_RST;
            sum_q  <= '0;
            cout_q <= COUT_RST;
`ifdef SERIAL_ADD_SUB_EN
            sub_q  <= 1'b0;
`endif
        end else if (accept) begin
            cnt    <= '0;
`ifdef SERIAL_ADD_SUB_EN
            carry  <= bus.sub;
            sub_q  <= bus.sub;
`else
            carry  <= 1'b0;
`endif
        end else if (step) begin
            cnt   <= cnt + CW'(1);
            carry <= fa_c;
            if (last) begin
                sum_q  <= sum_nx;
                cout_q <= fa_c;
            end
        end
    end

    // Operand and partial-sum shifters carry no reset: they are always
    // reloaded on accept and fully overwritten before the result is used.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_sh <= bus.a;
            b_sh <= bus.b;
        end else if (step) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            sum_sh <= sum_nx;
        end
    end

    assign bus.busy = busy_c;
    assign bus.done = done_c;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at WIDTH=8 and WIDTH=4.
module tb_serial_add_ctrl;

`ifdef SERIAL_ADD_SUB_EN
    localparam bit SUB_ON = 1'b1;
`else
    localparam bit SUB_ON = 1'b0;
`endif

    typedef struct {
        int         acc;
        logic [7:0] sum;
        logic       cout;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic sub8  = 1'b0;
    logic sub4  = 1'b0;

    always #5 clk = ~clk;

    serial_add_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_add_ctrl_if #(.WIDTH(4)) bus4 ();

`ifdef SERIAL_ADD_SUB_EN
    assign bus8.sub = sub8;
    assign bus4.sub = sub4;
`endif

    serial_add_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    serial_add_ctrl #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    exp_t       q8[$];
    exp_t       q4[$];
    int         cyc    = 0;
    int         free8  = 0;
    int         free4  = 0;
    logic [7:0] last8  = 8'h00;
    logic       lastc8 = 1'b0;
    logic [3:0] last4  = 4'h0;
    logic       lastc4 = 1'b0;
    int         checks = 0;
    int         passes = 0;

    // Reference: unsigned add or two's-complement subtract modulo 2^w.
    function automatic exp_t ref_op(input int w, input int av, input int bv,
                                    input bit s, input int acc);
        exp_t r;
        int   m;
        m     = 1 << w;
        r.acc = acc;
        if (s) begin
            r.sum  = 8'((av - bv + m) % m);
            r.cout = (av >= bv);
        end else begin
            r.sum  = 8'((av + bv) % m);
            r.cout = ((av + bv) >= m);
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Model: an idle unit accepts start; busy for WIDTH cycles, then done.
    always @(posedge clk) begin
        if (!rst_n) begin
            q8.delete();
            q4.delete();
            free8 <= 0;
            free4 <= 0;
        end else begin
            if (bus8.start && cyc >= free8) begin
                q8.push_back(ref_op(8, int'(bus8.a), int'(bus8.b), sub8 & SUB_ON, cyc));
                free8 <= cyc + 10;
            end
            if (bus4.start && cyc >= free4) begin
                q4.push_back(ref_op(4, int'(bus4.a), int'(bus4.b), sub4 & SUB_ON, cyc));
                free4 <= cyc + 6;
            end
        end
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_busy8", 32'(bus8.busy), 32'(0));
            chk("rst_done8", 32'(bus8.done), 32'(0));
            chk("rst_sum8",  32'(bus8.sum),  32'(0));
            chk("rst_cout8", 32'(bus8.cout), 32'(0));
            last8  <= 8'h00;
            lastc8 <= 1'b0;
        end else begin
            chk("done8", 32'(bus8.done), 32'((q8.size() > 0) ? (cyc == q8[0].acc + 9) : 1'b0));
            chk("busy8", 32'(bus8.busy),
                32'((q8.size() > 0) ? (cyc > q8[0].acc && cyc < q8[0].acc + 9) : 1'b0));
            if (q8.size() > 0 && cyc == q8[0].acc + 9) begin
                chk("sum8",  32'(bus8.sum),  32'(q8[0].sum));
                chk("cout8", 32'(bus8.cout), 32'(q8[0].cout));
                last8  <= q8[0].sum;
                lastc8 <= q8[0].cout;
                void'(q8.pop_front());
            end else begin
                chk("hold_sum8",  32'(bus8.sum),  32'(last8));
                chk("hold_cout8", 32'(bus8.cout), 32'(lastc8));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_sum4", 32'(bus4.sum), 32'(0));
            last4  <= 4'h0;
            lastc4 <= 1'b0;
        end else begin
            chk("done4", 32'(bus4.done), 32'((q4.size() > 0) ? (cyc == q4[0].acc + 5) : 1'b0));
            chk("busy4", 32'(bus4.busy),
                32'((q4.size() > 0) ? (cyc > q4[0].acc && cyc < q4[0].acc + 5) : 1'b0));
            if (q4.size() > 0 && cyc == q4[0].acc + 5) begin
                chk("sum4",  32'(bus4.sum),  32'(q4[0].sum[3:0]));
                chk("cout4", 32'(bus4.cout), 32'(q4[0].cout));
                last4  <= q4[0].sum[3:0];
                lastc4 <= q4[0].cout;
                void'(q4.pop_front());
            end else begin
                chk("hold_sum4",  32'(bus4.sum),  32'(last4));
                chk("hold_cout4", 32'(bus4.cout), 32'(lastc4));
            end
        end
    end

    task automatic d8(input bit st, input logic [7:0] av, input logic [7:0] bv, input bit sv);
        @(posedge clk);
        #1;
        bus8.start = st;
        bus8.a     = av;
        bus8.b     = bv;
        sub8       = sv;
    endtask

    task automatic d4(input bit st, input logic [3:0] av, input logic [3:0] bv, input bit sv);
        @(posedge clk);
        #1;
        bus4.start = st;
        bus4.a     = av;
        bus4.b     = bv;
        sub4       = sv;
    endtask

    task automatic idle8(input int n);
        repeat (n) d8(1'b0, 8'($urandom), 8'($urandom), 1'b0);
    endtask

    initial begin
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
        bus4.start = 1'b0; bus4.a = '0; bus4.b = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Zero operands, then carry-out and no-carry patterns.
        d8(1, 8'h00, 8'h00, 0); idle8(11);
        d8(1, 8'hFF, 8'h01, 0); idle8(11);
        d8(1, 8'h5A, 8'hA5, 0); idle8(11);

        // Starts during RUN (cycle 3) and DONE (cycle 9) are ignored.
        d8(1, 8'h12, 8'h34, 0);
        idle8(2); d8(1, 8'hAA, 8'hBB, 0);
        idle8(5); d8(1, 8'hCC, 8'hDD, 0);
        idle8(14);

        // Reset mid-run aborts without done; next start completes.
        d8(1, 8'h33, 8'h44, 0); idle8(4);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        d8(1, 8'h07, 8'h09, 0); idle8(12);

        // Start held high: back-to-back accepts every WIDTH+2 cycles.
        repeat (40) d8(1, 8'($urandom), 8'($urandom), 0);
        idle8(12);

        // Subtract vectors (plain adds when the subtract mode is absent).
        d8(1, 8'h10, 8'h01, 1); idle8(11);
        d8(1, 8'h01, 8'h02, 1); idle8(11);

        // Random operands with random extra start pulses.
        repeat (40) begin
            d8(1, 8'($urandom), 8'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 12))
                d8(($urandom_range(0, 3) == 0), 8'($urandom), 8'($urandom), 1'($urandom));
        end
        idle8(12);

        // Exhaustive WIDTH=4 sweep.
        for (int av = 0; av < 16; av++)
            for (int bv = 0; bv < 16; bv++)
                for (int sv = 0; sv <= int'(SUB_ON); sv++) begin
                    d4(1, 4'(av), 4'(bv), 1'(sv));
                    repeat (5) d4(0, 4'(av), 4'(bv), 1'(sv));
                end
        repeat (15) d4(0, 4'h0, 4'h0, 0);

        chk("drain8", 32'(q8.size()), 32'(0));
        chk("drain4", 32'(q4.size()), 32'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
